// File: rtl/sa_output_deskew_if.sv
// -----------------------------------------------------------------------------
// sa_output_deskew_if
// Bundles the bottom-row capture inputs, the advance/token controls and the
// downstream valid/ready result bus of the systolic-array output deskewer.
//
// Signals:
//   sa_outputs   : bottom-row outputs of the array, element c = column c
//   advance      : one array advance step this cycle
//   in_valid     : element 0 of a valid vector enters row 0 this step
//   can_advance  : deskewer can absorb a push this cycle
//   out_valid    : result vector available
//   out_ready    : downstream accepts out_data
//   out_data     : aligned result vector, element c = column c
//   err_overflow : sticky push-while-full flag (only with
//                  SA_DESKEW_OVERFLOW_FLAG_EN defined)
//
// Modports: slave = the deskewer, master = array/controller/downstream side.
// -----------------------------------------------------------------------------
interface sa_output_deskew_if #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8
);
  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_outputs;
  logic                                    advance;
  logic                                    in_valid;
  logic                                    can_advance;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] out_data;
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
  logic                                    err_overflow;
`endif

  modport slave (
    input  sa_outputs, advance, in_valid, out_ready,
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
    output err_overflow,
`endif
    output can_advance, out_valid, out_data
  );

  modport master (
    output sa_outputs, advance, in_valid, out_ready,
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
    input  err_overflow,
`endif
    input  can_advance, out_valid, out_data
  );
endinterface

// File: rtl/sa_output_deskew.sv
// -----------------------------------------------------------------------------
// sa_output_deskew
// Collects the skewed per-column results from the systolic array's bottom row,
// re-aligns them into whole result vectors, buffers them in a small FIFO and
// hands them downstream on a valid/ready handshake. can_advance tells the GEMM
// controller whether the FIFO can take the push a future advance may cause.
//
// Ports:
//   clk    : clock
//   resetn : synchronous, active-low reset (clears tokens, delay lines, FIFO)
//   bus    : sa_output_deskew_if.slave (see interface header for signals)
//
// Optional feature: define SA_DESKEW_OVERFLOW_FLAG_EN to get the sticky
// err_overflow output, set when a push arrives while the FIFO is full.
// -----------------------------------------------------------------------------
module sa_output_deskew #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               resetn,
  sa_output_deskew_if.slave  bus
);

  // Token age at which the last column's result is live on the array output.
  localparam int VLD_LEN = 2 * SA_SIZE - 2;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] vec_t;

  logic [VLD_LEN-1:0] r_vld_sr;
  vec_t               w_entry;
  vec_t               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;

  // ---- Token pipeline: r_vld_sr[k] is the token presented k+1 steps ago ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld_sr <= '0;
    end else if (bus.advance) begin
      r_vld_sr <= {r_vld_sr[VLD_LEN-2:0], bus.in_valid};
    end
  end

  // ---- Column delay lines: column c waits N-1-c steps for the last column ----
  for (genvar c = 0; c < SA_SIZE - 1; c++) begin : g_dly
    localparam int D = SA_SIZE - 1 - c;
    logic [ACTIVATION_SIZE-1:0] r_line [D];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int k = 0; k < D; k++) r_line[k] <= '0;
      end else if (bus.advance) begin
        r_line[0] <= bus.sa_outputs[c];
        for (int k = 1; k < D; k++) r_line[k] <= r_line[k-1];
      end
    end

    assign w_entry[c] = r_line[D-1];
  end

  // The last column is produced exactly when the token completes.
  assign w_entry[SA_SIZE-1] = bus.sa_outputs[SA_SIZE-1];

  // ---- FIFO push/pop: full is judged from registered count only ----
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_req = bus.advance & r_vld_sr[VLD_LEN-1];
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_count != '0) & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.can_advance = ~w_full;
  assign bus.out_valid   = (r_count != '0);
  assign bus.out_data    = r_mem[r_rd_ptr];

`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
  logic r_err_overflow;

  // Sticky until reset; the offending entry is dropped regardless.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_overflow <= 1'b0;
    end else if (w_push_req & w_full) begin
      r_err_overflow <= 1'b1;
    end
  end

  assign bus.err_overflow = r_err_overflow;
`endif

endmodule

// File: tb/tb_sa_output_deskew.sv
module tb_sa_output_deskew;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2 * N - 2;
  localparam int HSZ   = 4096;

  typedef logic [N-1:0][AW-1:0] vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sa_output_deskew_if #(.SA_SIZE(N), .ACTIVATION_SIZE(AW)) bus ();

  sa_output_deskew #(
    .SA_SIZE(N), .ACTIVATION_SIZE(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: per-step history of array outputs and token flags; a
  // token accepted at step t yields element c = outputs of step t+N-1+c,
  // column c, queued at step t+2N-2 unless the queue already holds DEPTH.
  vec_t m_q[$];
  vec_t hist [HSZ];
  bit   tok  [HSZ];
  int   m_step = 0;
  bit   m_err  = 1'b0;
  vec_t got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t pattern(input int s);
    vec_t v;
    for (int c = 0; c < N; c++) v[c] = AW'((s << 4) | c);
    return v;
  endfunction

  task automatic model_step();
    vec_t v;
    int   t;
    bit   pop, full, push;
    if (!resetn) begin
      m_q.delete();
      m_step = 0;
      m_err  = 1'b0;
      foreach (tok[i]) tok[i] = 1'b0;
      return;
    end
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    pop  = (m_q.size() != 0) && bus.out_ready;
    full = (m_q.size() == DEPTH);
    push = 1'b0;
    v    = '0;
    if (bus.advance) begin
      hist[m_step % HSZ] = bus.sa_outputs;
      tok[m_step % HSZ]  = bus.in_valid;
      t = m_step - LAT;
      if (t >= 0 && tok[t % HSZ]) begin
        for (int c = 0; c < N; c++) v[c] = hist[(t + N - 1 + c) % HSZ][c];
        push = 1'b1;
      end
      m_step++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (full) m_err = 1'b1;
      else      m_q.push_back(v);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("can_advance", 32'(bus.can_advance), 32'(m_q.size() < DEPTH));
    if (m_q.size() != 0) chk("out_data", bus.out_data, m_q[0]);
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
    chk("err_overflow", 32'(bus.err_overflow), 32'(m_err));
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_pat();
    bus.sa_outputs = pattern(m_step);
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    bus.advance  = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  initial begin
    resetn         = 1'b0;
    bus.sa_outputs = '0;
    bus.advance    = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    do_reset();
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_can_advance", 32'(bus.can_advance), 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
    chk("rst_err", 32'(bus.err_overflow), 32'd0);
`endif

    // Single token at step 0
    got.delete();
    bus.out_ready = 1'b1;
    bus.advance   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 0);
      set_pat();
      cycle();
      if (i == 5) chk("t1_no_early", 32'(bus.out_valid), 32'd0);
      if (i == 6) begin
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data", bus.out_data, 32'h63524130);
      end
      if (i == 7) chk("t1_one_cycle", 32'(bus.out_valid), 32'd0);
    end
    chk("t1_count", got.size(), 32'd1);

    // Eight back-to-back tokens
    do_reset();
    got.delete();
    bus.out_ready = 1'b1;
    bus.advance   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i < 8);
      set_pat();
      cycle();
    end
    chk("t2_count", got.size(), 32'd8);
    chk("t2_vec0", got[0], 32'h63524130);
    chk("t2_vec7", got[7], 32'hD3C2B1A0);

    // Advance dropped for three cycles mid-flight
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.advance  = !(i >= 3 && i < 6);
      bus.in_valid = (i == 0);
      if (bus.advance) set_pat();
      else             bus.sa_outputs = vec_t'($urandom());
      cycle();
      if (i == 8) chk("t3_no_early", 32'(bus.out_valid), 32'd0);
      if (i == 9) begin
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_data", bus.out_data, 32'h63524130);
      end
    end

    // Fill with out_ready low, keep advancing past full, then drain
    do_reset();
    bus.out_ready = 1'b0;
    bus.advance   = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = (i < 6);
      set_pat();
      cycle();
      if (i == 8) chk("t4_not_full", 32'(bus.can_advance), 32'd1);
      if (i == 9) chk("t4_full", 32'(bus.can_advance), 32'd0);
      if (i >= 9) chk("t4_hold", bus.out_data, 32'h63524130);
    end
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
    chk("t4_err_set", 32'(bus.err_overflow), 32'd1);
`endif
    got.delete();
    bus.advance   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("t4_drain_count", got.size(), 32'd4);
    chk("t4_drain_vec1", got[1], 32'h73625140);
    chk("t4_drain_vec3", got[3], 32'h93827160);
`ifdef SA_DESKEW_OVERFLOW_FLAG_EN
    chk("t4_err_sticky", 32'(bus.err_overflow), 32'd1);
`endif

    // Reset with two entries buffered and two tokens in flight
    do_reset();
    bus.out_ready = 1'b0;
    bus.advance   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i == 0 || i == 1 || i == 6 || i == 7);
      set_pat();
      cycle();
    end
    chk("t5_buffered", 32'(bus.out_valid), 32'd1);
    resetn       = 1'b0;
    bus.in_valid = 1'b1;
    cycle();
    resetn = 1'b1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_can_adv", 32'(bus.can_advance), 32'd1);
    chk("t5_rst_data", bus.out_data, 32'd0);
    got.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_pat();
      cycle();
    end
    chk("t5_no_output", got.size(), 32'd0);

    // Randomized traffic with stalls, back-pressure and occasional overrun
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.sa_outputs = vec_t'($urandom());
      bus.in_valid   = ($urandom_range(0, 2) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      if (bus.can_advance) bus.advance = ($urandom_range(0, 4) != 0);
      else                 bus.advance = ($urandom_range(0, 9) == 0);
      resetn = !($urandom_range(0, 599) == 0);
      cycle();
      resetn = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sa_output_deskew.md
# sa_output_deskew

Output-side collector for the fixed-weight systolic array. It captures the skewed per-column results from the array's bottom row and re-aligns them into complete result vectors. Each vector is buffered in a small FIFO and presented downstream on a valid/ready handshake. It also produces `can_advance`, which the GEMM controller ANDs into `should_advance_computation` so the array never produces a result the block cannot store.

## Interface
- `SA_SIZE`, 8: array dimension N; number of result columns.
- `ACTIVATION_SIZE`, 8: width of each result element.
- `FIFO_DEPTH`, 4: result-vector FIFO entries; power of two, ≥2.

- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `sa_outputs`  in  `ACTIVATION_SIZE` × `SA_SIZE`  bottom-row outputs of the array (combinational from the array).
- `advance`  in  1  the array's `should_advance_computation` for this cycle; one "advance step".
- `in_valid`  in  1  marks that element 0 of a valid input vector enters array row 0 in this advance step. The feeder applies row-r skew of r steps. Sampled only when `advance`=1.
- `can_advance`  out  1  high when the FIFO can absorb a push this cycle.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts `out_data` when `out_valid`&`out_ready`.
- `out_data`  out  `ACTIVATION_SIZE` × `SA_SIZE`  aligned result vector; element c = column c.
- `err_overflow`  out  1  only present with `SA_DESKEW_OVERFLOW_FLAG_EN`.

## Operation
- Token pipeline: `vld_sr[0..2N-3]`, shifted on `advance` only.
  - `vld_sr[0]` <= `in_valid`; `vld_sr[k]` <= `vld_sr[k-1]`.
  - `vld_sr[k]` = token presented k+1 advances ago.
- Column c result for a token appears on `sa_outputs[c]` during the advance step at token age N-1+c (age 0 = step of `in_valid`).
- Delay lines: column c (c < N-1) has a shift register of depth N-1-c.
  - Input is `sa_outputs[c]`; it shifts on `advance`.
  - Not valid-gated; contents are data only.
  - Column N-1 uses `sa_outputs[N-1]` directly.
- Push: when `advance` & `vld_sr[2N-3]`, write one FIFO entry.
  - Entry = {tail of each delay line c < N-1, live `sa_outputs[N-1]`}.
  - All columns then belong to the same token.
- Invalid steps (bubbles) produce no push; delay lines still shift.
- FIFO: `wr_ptr`/`rd_ptr` of log2(`FIFO_DEPTH`) bits with natural wrap, plus `count` 0..`FIFO_DEPTH`.
  - Pop on `out_valid`&`out_ready`.
  - Simultaneous push and pop leaves `count` unchanged; both pointers advance.
- `can_advance` = (`count` < `FIFO_DEPTH`). It is registered-state only, with no combinational path from `out_ready`. At most one push occurs per advance step, so obeying it prevents overflow.
- Push while full (controller ignored `can_advance`): the entry is dropped, FIFO state is unchanged, and behaviour is as in Configuration.
- `out_data` = `mem[rd_ptr]`. It is held stable while `out_valid`&!`out_ready`.
- No arithmetic; results pass through bit-exact.

## Timing
- Reset, synchronous, any cycle including mid-operation:
  - `vld_sr`, delay lines, FIFO memory, pointers and `count` all clear to 0.
  - `out_valid`=0, `out_data`=0, `can_advance`=1, `err_overflow`=0.
  - In-flight tokens are discarded.
- Latency: the token accepted at advance step s is pushed at the clock edge ending advance step s+2N-2. `out_valid` rises the next cycle if the FIFO was empty.
- `advance`=0 cycles freeze `vld_sr` and the delay lines. Latency counts advance steps, not cycles.
- Throughput: one vector per advance step with `out_ready` held high.

## Configuration
- `SA_DESKEW_OVERFLOW_FLAG_EN` defined:
  - `err_overflow` port exists.
  - It is a sticky flag set on push-while-full and cleared only by reset.
  - The dropped entry is still discarded.
- Undefined:
  - The port is absent.
  - Push-while-full is silently dropped.

## Test plan
Tests run with N=4, `FIFO_DEPTH`=4, `advance` held high unless noted, and `sa_outputs[c]` = (step<<4)|c.
- Single token at step 0 -> exactly one push after step 6; `out_data` = {0x30,0x41,0x52,0x63}; `out_valid` for one cycle with `out_ready`=1.
- `in_valid` at steps 0..7 with `out_ready`=1 -> 8 consecutive vectors; vector k = {(3+k)<<4|0, (4+k)<<4|1, (5+k)<<4|2, (6+k)<<4|3}.
- Token at step 0, then `advance` dropped for 3 cycles mid-flight -> same vector {0x30,0x41,0x52,0x63}, delivered 3 cycles later.
- `out_ready`=0 with tokens every step -> `can_advance` falls after the 4th push; `count`=4; `out_data` stable; raising `out_ready` drains in order.
- Force `advance`=1 while full with a token due -> entry dropped, `count` stays 4; with the macro, `err_overflow`=1 until reset.
- Assert `resetn`=0 for one cycle with 2 tokens in flight and 2 entries buffered -> `out_valid`=0, `can_advance`=1, and no output afterwards.
